seg7_scan_driver: RTL

//  Downstream display stage for the 0..19 up/down counter. Takes the counter's
//  5-bit binary value and drives a two-digit multiplexed 7-segment display
//  (tens + ones), scanning one digit at a time.

---
 rtl/seg7_scan_driver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver for a 0..19 value: frame-aligned sampling,
// leading-zero blanking, dash for out-of-range, optional whole-display blink.
module seg7_scan_driver #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLINK_DIV      = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] VAL,
    input  logic       BLINK,
    output logic [6:0] SEG,
    output logic [1:0] AN
);

    localparam int RC_W = $clog2(REFRESH_DIV);
    localparam int BC_W = $clog2(BLINK_DIV);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF  = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

    // Internal digit codes: 0..9 numerals, DASH and BLANK as out-of-band symbols
    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_t;

    slot_t           slot_reg, slot_next;
    logic [RC_W-1:0] rc_reg;
    logic [BC_W-1:0] bc_reg;
    logic            phase_reg;
    logic [4:0]      val_q_reg;
    logic            rc_last;

    logic [3:0]      digit     [2];
    logic [6:0]      digit_seg [2];
    logic [4:0]      ones_wide;
    logic [6:0]      seg_on;
    logic [1:0]      an_on;
    logic [6:0]      seg_next;
    logic [1:0]      an_next;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            DIG_DASH: s = 7'h40;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign rc_last = (rc_reg == RC_LAST);

    // Slot FSM: state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_reg <= SLOT_ONES;
        end else begin
            slot_reg <= slot_next;
        end
    end

    // Slot FSM: next state
    always_comb begin
        slot_next = slot_reg;
        if (rc_last) begin
            slot_next = (slot_reg == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
        end
    end

    // Refresh/blink counters; VAL is captured only at frame start so digits never tear
    always_ff @(posedge CLK) begin
        if (RST) begin
            rc_reg    <= '0;
            bc_reg    <= '0;
            phase_reg <= 1'b0;
            val_q_reg <= '0;
        end else begin
            rc_reg <= rc_last ? '0 : rc_reg + 1'b1;
            if (slot_reg == SLOT_TENS && rc_last) begin
                val_q_reg <= VAL;
            end
            if (!BLINK) begin
                bc_reg    <= '0;
                phase_reg <= 1'b0;
            end else if (bc_reg == BC_LAST) begin
                bc_reg    <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                bc_reg <= bc_reg + 1'b1;
            end
        end
    end

    // Split val_q into digit codes: index 0 = ones, index 1 = tens
    assign ones_wide = val_q_reg - 5'd10;

    always_comb begin
        digit[0] = val_q_reg[3:0];
        digit[1] = DIG_BLANK;
        if (val_q_reg >= 5'd20) begin
            digit[0] = DIG_DASH;
            digit[1] = DIG_DASH;
        end else if (val_q_reg >= 5'd10) begin
            digit[0] = ones_wide[3:0];
            digit[1] = 4'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit
            assign digit_seg[gi] = seg_lut(digit[gi]);
        end
    endgenerate

    // Slot FSM: outputs (active-high, then mapped to the board polarity)
    always_comb begin
        seg_on = 7'h00;
        an_on  = 2'b00;
        if (!phase_reg) begin
            if (slot_reg == SLOT_ONES) begin
                seg_on = digit_seg[0];
                an_on  = 2'b01;
            end else if (digit[1] != DIG_BLANK) begin
                seg_on = digit_seg[1];
                an_on  = 2'b10;
            end
        end
        seg_next = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        an_next  = AN_ACTIVE_LOW ? ~an_on : an_on;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SEG <= SEG_OFF;
            AN  <= AN_OFF;
        end else begin
            SEG <= seg_next;
            AN  <= an_next;
        end
    end

endmodule
